div_iter: RTL and testbench

DIV_ITER -- requirements
Module: div_iter

---
 rtl/div_iter_if.sv | 28 ++
 rtl/div_iter.sv | 123 ++++++++++++
 tb/tb_div_iter.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/div_iter_if.sv
// div_iter_if -- handshake/data bundle between the pipeline and the
// iterative divider.
//   master : pipeline side; drives start, signed_div, dividend, divisor and
//            annul, and observes busy, stall, ready and result.
//   slave  : divider side; the mirror image of master.
interface div_iter_if #(
  parameter int WIDTH = 32
);
  logic                 start;
  logic                 signed_div;
  logic [WIDTH-1:0]     dividend;
  logic [WIDTH-1:0]     divisor;
  logic                 annul;
  logic                 busy;
  logic                 stall;
  logic                 ready;
  logic [2*WIDTH-1:0]   result;

  modport master (
    output start, signed_div, dividend, divisor, annul,
    input  busy, stall, ready, result
  );

  modport slave (
    input  start, signed_div, dividend, divisor, annul,
    output busy, stall, ready, result
  );
endinterface

// File: rtl/div_iter.sv
// div_iter -- iterative restoring divider (DIV / DIVU), one quotient bit per
// clock, MSB first.
//   clk    : single clock, rising edge
//   resetn : asynchronous active-low reset
//   bus    : div_iter_if.slave
//            start/signed_div/dividend/divisor : request, sampled in IDLE
//            annul  : flush; abandons the current or requested operation
//            busy   : registered, high while not IDLE
//            stall  : combinational pipeline hold
//            ready  : registered one-cycle completion pulse
//            result : registered {remainder, quotient}, held between readies
// Optional feature: define DIV_ZERO_FAST_EN to finish a divide-by-zero in
// two cycles with result {dividend, all ones}.
//
// state | meaning
// IDLE  | waiting for an accepted start
// RUN   | WIDTH shift-subtract steps on magnitudes
// DONE  | apply signs, register result, pulse ready
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       resetn,
  div_iter_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvs;
  logic [CW-1:0]    cnt;
  logic             q_neg;
  logic             r_neg;
  logic             dz;

  logic             accept;
  logic [WIDTH-1:0] abs_dvd;
  logic [WIDTH-1:0] abs_dvs;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] q_fin;
  logic [WIDTH-1:0] r_fin;

  assign accept    = bus.start & ~bus.annul & (state == IDLE);
  assign bus.stall = accept | bus.busy;

  assign abs_dvd = (bus.signed_div & bus.dividend[WIDTH-1]) ? -bus.dividend : bus.dividend;
  assign abs_dvs = (bus.signed_div & bus.divisor[WIDTH-1])  ? -bus.divisor  : bus.divisor;

  // rem < dvs holds throughout, so bit WIDTH of diff is the borrow.
  assign shifted = {rem, quo[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvs};

  assign q_fin = q_neg ? -quo : quo;
  assign r_fin = r_neg ? -rem : rem;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      quo        <= '0;
      rem        <= '0;
      dvs        <= '0;
      cnt        <= '0;
      q_neg      <= 1'b0;
      r_neg      <= 1'b0;
      dz         <= 1'b0;
      bus.busy   <= 1'b0;
      bus.ready  <= 1'b0;
      bus.result <= '0;
    end else begin
      bus.ready <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            q_neg    <= bus.signed_div & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
            r_neg    <= bus.signed_div & bus.dividend[WIDTH-1];
            quo      <= abs_dvd;
            rem      <= '0;
            dvs      <= abs_dvs;
            cnt      <= '0;
            dz       <= 1'b0;
            bus.busy <= 1'b1;
            state    <= RUN;
`ifdef DIV_ZERO_FAST_EN
            // Skip iteration; quo carries the raw dividend into DONE.
            if (bus.divisor == '0) begin
              quo   <= bus.dividend;
              dz    <= 1'b1;
              state <= DONE;
            end
`endif
          end
        end
        RUN: begin
          if (bus.annul) begin
            bus.busy <= 1'b0;
            state    <= IDLE;
          end else begin
            quo <= {quo[WIDTH-2:0], ~diff[WIDTH]};
            rem <= diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
            cnt <= cnt + CW'(1);
            if (cnt == CW'(WIDTH - 1)) state <= DONE;
          end
        end
        DONE: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
          if (!bus.annul) begin
            bus.ready  <= 1'b1;
            bus.result <= dz ? {quo, {WIDTH{1'b1}}} : {r_fin, q_fin};
          end
        end
        default: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_div_iter.sv
module tb_div_iter;
  localparam int W = 32;

`ifdef DIV_ZERO_FAST_EN
  localparam int ZLAT = 2;
`else
  localparam int ZLAT = 34;
`endif

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  div_iter_if #(.WIDTH(W)) bus();
  div_iter #(.WIDTH(W)) dut (.clk(clk), .resetn(resetn), .bus(bus));

  int          total = 0;
  int          bad = 0;
  logic [63:0] last_res = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division in 64-bit arithmetic, truncating toward
  // zero with remainder taking the dividend's sign; keep the low 32 bits.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic sg);
    longint q;
    longint r;
    if (sg) begin
      q = longint'($signed(a)) / longint'($signed(b));
      r = longint'($signed(a)) % longint'($signed(b));
    end else begin
      q = longint'({32'b0, a}) / longint'({32'b0, b});
      r = longint'({32'b0, a}) % longint'({32'b0, b});
    end
    return {r[31:0], q[31:0]};
  endfunction

  // Caller sits at a falling edge; start is raised for that cycle (cycle 0).
  // Returns at the falling edge of the ready cycle, or after 45 cycles.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sg,
                        input int repulse_at, input int annul_at,
                        output int lat_o, output logic busy_ok, output logic held_ok);
    logic annulled;
    bus.dividend   = a;
    bus.divisor    = b;
    bus.signed_div = sg;
    bus.annul      = 1'b0;
    bus.start      = 1'b1;
    #1 chk("stall_on_accept", 64'(bus.stall), 64'd1);
    @(negedge clk);
    bus.start = 1'b0;
    lat_o = 0; busy_ok = 1'b1; held_ok = 1'b1; annulled = 1'b0;
    for (int j = 1; j <= 45; j++) begin
      if (bus.ready === 1'b1) begin
        lat_o = j;
        if (bus.busy !== 1'b0) busy_ok = 1'b0;
        break;
      end
      if (bus.busy !== !annulled) busy_ok = 1'b0;
      if (bus.result !== last_res) held_ok = 1'b0;
      bus.start = (j == repulse_at);
      if (j == repulse_at) bus.dividend = $urandom;
      bus.annul = (j == annul_at);
      if (j == annul_at) annulled = 1'b1;
      @(negedge clk);
    end
    bus.start = 1'b0;
    bus.annul = 1'b0;
  endtask

  initial begin
    int          lat;
    logic        bok;
    logic        hok;
    logic        quiet;
    logic [31:0] a;
    logic [31:0] b;
    logic        sg;
    logic [63:0] exp;

    resetn = 1'b0;
    bus.start = 1'b0; bus.signed_div = 1'b0; bus.annul = 1'b0;
    bus.dividend = '0; bus.divisor = '0;
    #23;
    chk("reset_busy",   64'(bus.busy),  64'd0);
    chk("reset_ready",  64'(bus.ready), 64'd0);
    chk("reset_result", bus.result,     64'd0);
    chk("reset_stall",  64'(bus.stall), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    // DIVU 100/7
    run_op(32'd100, 32'd7, 1'b0, 0, 0, lat, bok, hok);
    chk("divu_100_7_lat",  64'(lat), 64'd34);
    chk("divu_100_7_busy", 64'(bok), 64'd1);
    chk("divu_100_7_hold", 64'(hok), 64'd1);
    chk("divu_100_7_res",  bus.result, {32'd2, 32'd14});
    last_res = {32'd2, 32'd14};
    @(negedge clk);
    chk("ready_is_pulse", 64'(bus.ready), 64'd0);

    // DIV -7/2
    run_op(-32'sd7, 32'd2, 1'b1, 0, 0, lat, bok, hok);
    chk("div_m7_2_lat", 64'(lat), 64'd34);
    chk("div_m7_2_res", bus.result, {32'hFFFFFFFF, 32'hFFFFFFFD});
    last_res = {32'hFFFFFFFF, 32'hFFFFFFFD};
    @(negedge clk);

    // signed overflow
    run_op(32'h80000000, 32'hFFFFFFFF, 1'b1, 0, 0, lat, bok, hok);
    chk("div_ovf_lat", 64'(lat), 64'd34);
    chk("div_ovf_res", bus.result, {32'd0, 32'h80000000});
    last_res = {32'd0, 32'h80000000};
    @(negedge clk);

    // start re-pulsed in cycle 10 is ignored, no queued operation
    run_op(32'd1000, 32'd3, 1'b0, 10, 0, lat, bok, hok);
    chk("repulse_lat",  64'(lat), 64'd34);
    chk("repulse_busy", 64'(bok), 64'd1);
    chk("repulse_res",  bus.result, {32'd1, 32'd333});
    last_res = {32'd1, 32'd333};
    quiet = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.ready !== 1'b0 || bus.busy !== 1'b0) quiet = 1'b0;
    end
    chk("repulse_not_queued", 64'(quiet), 64'd1);

    // back-to-back: second start in the first ready cycle
    run_op(32'd50000, 32'd9, 1'b0, 0, 0, lat, bok, hok);
    chk("b2b_first_lat", 64'(lat), 64'd34);
    chk("b2b_first_res", bus.result, model(32'd50000, 32'd9, 1'b0));
    last_res = model(32'd50000, 32'd9, 1'b0);
    run_op(32'hFFFF0000, 32'hFFFFFFF3, 1'b1, 0, 0, lat, bok, hok);
    chk("b2b_second_lat",  64'(lat), 64'd34);
    chk("b2b_second_hold", 64'(hok), 64'd1);
    chk("b2b_second_res",  bus.result, model(32'hFFFF0000, 32'hFFFFFFF3, 1'b1));
    last_res = model(32'hFFFF0000, 32'hFFFFFFF3, 1'b1);
    @(negedge clk);

    // annul in RUN (cycle 20) and in DONE (cycle 33)
    run_op(32'd777, 32'd5, 1'b0, 0, 20, lat, bok, hok);
    chk("annul_run_noready", 64'(lat), 64'd0);
    chk("annul_run_busy",    64'(bok), 64'd1);
    chk("annul_run_hold",    64'(hok), 64'd1);
    run_op(32'd778, 32'd5, 1'b0, 0, 33, lat, bok, hok);
    chk("annul_done_noready", 64'(lat), 64'd0);
    chk("annul_done_busy",    64'(bok), 64'd1);
    chk("annul_done_res",     bus.result, last_res);

    // start and annul together in IDLE
    bus.dividend = 32'd9; bus.divisor = 32'd3; bus.signed_div = 1'b0;
    bus.start = 1'b1; bus.annul = 1'b1;
    #1 chk("start_annul_stall", 64'(bus.stall), 64'd0);
    @(negedge clk);
    bus.start = 1'b0; bus.annul = 1'b0;
    quiet = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (bus.ready !== 1'b0 || bus.busy !== 1'b0) quiet = 1'b0;
      @(negedge clk);
    end
    chk("start_annul_ignored", 64'(quiet), 64'd1);

    // reset in cycle 15 of an operation
    bus.dividend = 32'd123456; bus.divisor = 32'd11; bus.signed_div = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (14) @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("midreset_busy",   64'(bus.busy),  64'd0);
    chk("midreset_ready",  64'(bus.ready), 64'd0);
    chk("midreset_result", bus.result,     64'd0);
    chk("midreset_stall",  64'(bus.stall), 64'd0);
    last_res = '0;
    @(negedge clk);
    resetn = 1'b1;
    quiet = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.ready !== 1'b0 || bus.busy !== 1'b0) quiet = 1'b0;
    end
    chk("midreset_no_ready", 64'(quiet), 64'd1);

    // randomized operations against the arithmetic model
    for (int n = 0; n < 24; n++) begin
      sg = 1'($urandom_range(0, 1));
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 2) == 0) b = 32'($urandom_range(1, 300));
      if (sg && $urandom_range(0, 1) == 1) b = -b;
      if ($urandom_range(0, 7) == 0) a = 32'h80000000;
      if (b == 32'd0) b = 32'd1;
      exp = model(a, b, sg);
      run_op(a, b, sg, 0, 0, lat, bok, hok);
      chk($sformatf("rand%0d_lat", n),  64'(lat), 64'd34);
      chk($sformatf("rand%0d_busy", n), 64'(bok), 64'd1);
      chk($sformatf("rand%0d_hold", n), 64'(hok), 64'd1);
      chk($sformatf("rand%0d_res a=%h b=%h s=%0d", n, a, b, sg), bus.result, exp);
      last_res = exp;
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
    @(negedge clk);

    // divide by zero
    run_op(32'd5, 32'd0, 1'b0, 0, 0, lat, bok, hok);
    chk("divzero_lat",  64'(lat), 64'(ZLAT));
    chk("divzero_busy", 64'(bok), 64'd1);
`ifdef DIV_ZERO_FAST_EN
    chk("divzero_res", bus.result, {32'd5, 32'hFFFFFFFF});
`endif
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
